// File: rtl/demux_pkg.sv
// demux_pkg: shared types and helpers for stream_demux_1xn.
// Holds the FSM state encoding and the select-width constant function.
package demux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    UNI   = 2'd1,
    BCAST = 2'd2
  } state_t;

  // Select width: max(1, clog2(n)), so that a 2-channel demux still has a 1-bit select.
  function automatic int calc_sw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_demux_1xn.sv
// stream_demux_1xn: 1-to-N valid/ready stream demultiplexer with unicast and
// broadcast delivery. A single word is held in a register; each channel keeps a
// pending bit that clears when that channel accepts the word.
// Optional feature: define DEMUX_SELCHK_EN to add the sticky sel_err output,
// which flags unicast words whose select is out of range (those words are
// always accepted and dropped).
module stream_demux_1xn
  import demux_pkg::*;
#(
  parameter int  DW = 8,
  parameter int  N  = 4,
  localparam int SW = calc_sw(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [SW-1:0]   in_sel,
  input  logic            in_bcast,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic [N*DW-1:0] out_data
`ifdef DEMUX_SELCHK_EN
  ,
  output logic            sel_err
`endif
);

  state_t        state;
  state_t        state_next;
  logic [DW-1:0] held_data;
  logic [SW-1:0] held_sel;
  logic [N-1:0]  pending;
  logic [N-1:0]  pending_after;
  logic [N-1:0]  load_mask;
  logic          accept;
  logic          sel_ok;
  logic          load;

  // A word is deliverable if it is a broadcast or names an existing channel.
  assign sel_ok = in_bcast || (int'(in_sel) < N);
  assign accept = in_valid && in_ready;
  assign load   = accept && sel_ok;

  // in_ready and next state: ready once the held word finishes draining this cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
    in_ready   = 1'b0;
    state_next = state;
    case (state)
      EMPTY:   in_ready = 1'b1;
      UNI:     in_ready = out_ready[held_sel];
      BCAST:   in_ready = ~|(pending & ~out_ready);
      default: in_ready = 1'b0;
    endcase
    if (load) begin
      state_next = in_bcast ? BCAST : UNI;
    end else if (pending_after == '0) begin
      state_next = EMPTY;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Hold register: captures each deliverable word; dropped words never load.
  always_ff @(posedge clk) begin
    // NOTE: the data register is reset on purpose so out_data reads zero after reset, not stale contents.
    if (rst) begin
      held_data <= '0;
      held_sel  <= '0;
    end else if (load) begin
      held_data <= in_data;
      held_sel  <= in_sel;
    end
  end

  // Per-channel pending/valid logic.
  for (genvar k = 0; k < N; k++) begin : g_chan
    logic pend_q;

    assign load_mask[k]     = in_bcast || (in_sel == SW'(k));
    assign pending_after[k] = pend_q && !out_ready[k];
    assign pending[k]       = pend_q;
    assign out_valid[k]     = pend_q;
    assign out_data[k*DW +: DW] = held_data;

    // Pending bit: set by a new word aimed here, cleared when this channel accepts.
    always_ff @(posedge clk) begin
      if (rst) begin
        pend_q <= 1'b0;
      end else if (load) begin
        pend_q <= load_mask[k];
      end else begin
        pend_q <= pending_after[k];
      end
    end
  end

`ifdef DEMUX_SELCHK_EN
  // Sticky flag for accepted-and-dropped out-of-range unicast words.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (accept && !sel_ok) begin
      sel_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/stream_demux_1xn.md
STREAM_DEMUX_1XN -- requirements
Module: stream_demux_1xn

Interface
REQ-001 Parameter DW, default 8, data width in bits.
REQ-002 Parameter N, default 4, output channel count; legal range 2..16.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  source word available.
REQ-006 Port in_ready  output  1  block accepts the word this cycle.
REQ-007 Port in_data  input  DW  source word.
REQ-008 Port in_sel  input  SW  destination channel index; SW = max(1, clog2(N)).
REQ-009 Port in_bcast  input  1  when high, deliver the word to all N channels and ignore in_sel.
REQ-010 Port out_valid  output  N  per-channel word available.
REQ-011 Port out_ready  input  N  per-channel sink accepts.
REQ-012 Port out_data  output  N*DW  per-channel data; slice k is bits [k*DW +: DW].
REQ-013 Port sel_err  output  1  sticky out-of-range select flag; present only when DEMUX_SELCHK_EN is defined.

Function
REQ-014 Transfers SHALL occur on an input when in_valid && in_ready, and on channel k when out_valid[k] && out_ready[k].
REQ-015 The block SHALL hold one word in a register (held_data, held_sel, pending[N]) and use an FSM with states EMPTY, UNI and BCAST.
REQ-016 In EMPTY, in_ready SHALL be 1 and out_valid SHALL be all zero.
REQ-017 In EMPTY, an accepted unicast word with in_sel < N SHALL go to UNI with pending = one-hot(in_sel).
REQ-018 In EMPTY, an accepted word with in_bcast = 1 SHALL go to BCAST with pending = all ones.
REQ-019 Latency SHALL be exactly 1 cycle from input acceptance to out_valid assertion; there is no combinational path from in_* to out_*.
REQ-020 out_valid SHALL equal pending; every out_data slice SHALL equal held_data.
REQ-021 In UNI, in_ready SHALL equal out_ready[held_sel], so a new word can be accepted in the cycle the held word drains (1 word/cycle throughput).
REQ-022 In BCAST, each accepting channel SHALL clear its pending bit; channels may accept in different cycles, and the same word SHALL never be delivered twice to one channel.
REQ-023 In BCAST, in_ready SHALL be 1 only in the cycle where (pending & ~out_ready) == 0, i.e. the last outstanding channels accept.
REQ-024 If the held word drains and no new word is accepted, the FSM SHALL return to EMPTY.
REQ-025 If the held word drains and a new word is accepted in the same cycle, the FSM SHALL load the new word and go directly to UNI or BCAST.
REQ-026 in_ready SHALL never depend on the out_ready of a channel that is not pending.
REQ-027 A unicast word with in_sel >= N SHALL be accepted and dropped: the FSM state and pending are left unchanged, and in_ready follows REQ-016/021/023.

Reset
REQ-028 While rst = 1 at a clock edge, the block SHALL enter EMPTY and clear pending, held_data and held_sel to 0.
REQ-029 After reset, out_valid SHALL be 0, out_data SHALL be 0, and in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-030 Reset mid-transfer (UNI or BCAST) SHALL discard the held word without completing any outstanding delivery.

Configuration
REQ-031 With macro DEMUX_SELCHK_EN defined, a word dropped per REQ-027 SHALL set sel_err to 1 on the next edge; sel_err clears only on reset.
REQ-032 Without DEMUX_SELCHK_EN, the sel_err port and its register SHALL not exist, and out-of-range words SHALL be dropped silently.

Structure
REQ-033 Package demux_pkg SHALL hold the FSM state enum (EMPTY, UNI, BCAST) and a constant function for SW.
REQ-034 The FSM and hold register SHALL live in stream_demux_1xn; per-channel pending/valid logic SHALL be a generate loop, not a sub-module.

Verification
REQ-035 Reset: rst = 1 for 2 cycles -> out_valid = 0, out_data = 0, in_ready = 1; with the macro, sel_err = 0.
REQ-036 Unicast stream: N=4, words 0xA1/sel=2 and 0xB2/sel=0 back-to-back, all out_ready = 1 -> out_valid = 0100 then 0001 on consecutive cycles, no bubbles.
REQ-037 Backpressure: unicast 0x5C/sel=3, out_ready[3] = 0 for 3 cycles -> out_valid = 1000 is held stable and in_ready = 0, then 1 cycle of drain.
REQ-038 Broadcast: 0x77/bcast, out_ready staggered (ch0 in cycle 1, ch1–2 in cycle 2, ch3 in cycle 4) -> each channel sees the word exactly once; in_ready = 1 only in cycle 4.
REQ-039 Out-of-range: N=3, sel=3 with 0xEE -> word is accepted, out_valid stays 000; with the macro, sel_err = 1 from the next cycle.
REQ-040 Reset mid-broadcast: assert rst with pending = 0110 -> the next cycle has out_valid = 0000 and in_ready = 1.
